ara_w_tracer: RTL and testbench

Synthesizable, multi-port successor to the simulation-only W-channel result dump. It passively snoops `NrPorts` AXI write-data channels and captures each accepted, enabled beat (data, strobe, port id) into a shared trace FIFO, which a drain interface reads out. Drop and capture counters make the trace usable on FPGA and in gate-level runs, where `$fdisplay` is unavailable. The tracer sits beside `ara_soc` and taps the VLSU port plus any additional AXI masters.

---
 rtl/ara_trace_pkg.sv | 30 +++
 rtl/ara_w_trace_stage.sv | 78 +++++++
 rtl/ara_w_tracer.sv | 172 +++++++++++++++++
 tb/tb_ara_w_tracer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_trace_pkg.sv
// Shared types and helpers for the W-channel tracer.
// The entry macro builds the FIFO record for a given data/port width.
`ifndef ARA_TRACE_ENTRY_T
`define ARA_TRACE_ENTRY_T(name_t, dw, pw) \
    typedef struct packed { \
        logic [(pw)-1:0]   port; \
        logic [(dw)/8-1:0] strb; \
        logic [(dw)-1:0]   data; \
    } name_t;
`endif

package ara_trace_pkg;

    localparam int unsigned CntWidth = 32;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } stage_state_e;

    function automatic logic [CntWidth-1:0] sat_add(
        input logic [CntWidth-1:0] a,
        input logic [3:0]          b
    );
        logic [CntWidth:0] s;
        s = {1'b0, a} + {{(CntWidth - 3){1'b0}}, b};
        return s[CntWidth] ? {CntWidth{1'b1}} : s[CntWidth-1:0];
    endfunction

endpackage

// File: rtl/ara_w_trace_stage.sv
// Per-port capture qualifier and single-entry staging register.
// A capture into an occupied, ungranted stage is dropped and flagged.
module ara_w_trace_stage
    import ara_trace_pkg::*;
#(
    parameter int unsigned DataWidth   = 128,
    parameter bit          FilterEmpty = 1'b1,
    parameter bit          MaskData    = 1'b1,
    localparam int unsigned StrbWidth  = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 port_en_i,
    input  logic                 w_valid_i,
    input  logic                 w_ready_i,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic [StrbWidth-1:0] w_strb_i,
    input  logic                 grant_i,
    output logic                 full_o,
    output logic [DataWidth-1:0] data_o,
    output logic [StrbWidth-1:0] strb_o,
    output logic                 drop_o
);

    stage_state_e         state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [StrbWidth-1:0] strb_q, strb_d;
    logic                 capture;
    logic [DataWidth-1:0] masked;

    always_comb begin
        capture = w_valid_i && w_ready_i && en_i && port_en_i &&
                  (!FilterEmpty || (|w_strb_i));
        masked = w_data_i;
        if (MaskData) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (!w_strb_i[b]) masked[b*8 +: 8] = 8'h00;
            end
        end
        state_d = state_q;
        data_d  = data_q;
        strb_d  = strb_q;
        drop_o  = 1'b0;
        if (clear_i) begin
            state_d = StEmpty;
        end else if (capture) begin
            // a granted stage is vacated this cycle, so it can take the new beat
            if (state_q == StEmpty || grant_i) begin
                state_d = StFull;
                data_d  = masked;
                strb_d  = w_strb_i;
            end else begin
                drop_o = 1'b1;
            end
        end else if (grant_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

    assign full_o = (state_q == StFull);
    assign data_o = data_q;
    assign strb_o = strb_q;

endmodule

// File: rtl/ara_w_tracer.sv
// Passive multi-port AXI W-channel tracer: per-port staging, round-robin
// merge into a shared trace FIFO, plus drop/capture counters.
module ara_w_tracer
    import ara_trace_pkg::*;
#(
    parameter int unsigned NrPorts     = 2,
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned Depth       = 16,
    parameter bit          FilterEmpty = 1'b1,
    parameter bit          MaskData    = 1'b1,
    localparam int unsigned StrbWidth  = DataWidth / 8,
    localparam int unsigned PortW      = (NrPorts > 1) ? $clog2(NrPorts) : 1,
    localparam int unsigned AddrW      = $clog2(Depth)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  logic [NrPorts-1:0]                  port_en_i,
    input  logic                                clear_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]   w_data_i,
    input  logic [NrPorts-1:0][StrbWidth-1:0]   w_strb_i,
    input  logic [NrPorts-1:0]                  w_valid_i,
    input  logic [NrPorts-1:0]                  w_ready_i,
    output logic                                trace_valid_o,
    input  logic                                trace_ready_i,
    output logic [DataWidth-1:0]                trace_data_o,
    output logic [StrbWidth-1:0]                trace_strb_o,
    output logic [PortW-1:0]                    trace_port_o,
    output logic                                overflow_o,
    output logic [CntWidth-1:0]                 drop_cnt_o,
    output logic [CntWidth-1:0]                 capt_cnt_o,
    output logic [AddrW:0]                      usage_o
);

    `ARA_TRACE_ENTRY_T(entry_t, DataWidth, PortW)

    logic [NrPorts-1:0]                stage_full;
    logic [NrPorts-1:0]                stage_drop;
    logic [NrPorts-1:0]                stage_grant;
    logic [NrPorts-1:0][DataWidth-1:0] stage_data;
    logic [NrPorts-1:0][StrbWidth-1:0] stage_strb;

    for (genvar p = 0; p < NrPorts; p++) begin : g_stage
        ara_w_trace_stage #(
            .DataWidth   (DataWidth),
            .FilterEmpty (FilterEmpty),
            .MaskData    (MaskData)
        ) i_stage (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .en_i      (en_i),
            .port_en_i (port_en_i[p]),
            .w_valid_i (w_valid_i[p]),
            .w_ready_i (w_ready_i[p]),
            .w_data_i  (w_data_i[p]),
            .w_strb_i  (w_strb_i[p]),
            .grant_i   (stage_grant[p]),
            .full_o    (stage_full[p]),
            .data_o    (stage_data[p]),
            .strb_o    (stage_strb[p]),
            .drop_o    (stage_drop[p])
        );
    end

    logic [PortW-1:0]    ptr_q, ptr_d;
    logic [PortW-1:0]    gnt_idx, cand;
    logic                gnt_any;
    entry_t              mem_q [Depth];
    entry_t              mem_d [Depth];
    entry_t              head;
    logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]      usage_q, usage_d;
    logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d, capt_cnt_q, capt_cnt_d;
    logic                ovf_q, ovf_d;
    logic                fifo_full, push, pop;
    logic [3:0]          n_drop;

    // Rotating-priority search starting at the port after the last winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < int'(NrPorts); i++) begin
            cand = PortW'((int'(ptr_q) + i) % int'(NrPorts));
            if (!gnt_any && stage_full[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign fifo_full     = (usage_q == (AddrW + 1)'(Depth));
    assign trace_valid_o = (usage_q != '0);
    assign pop           = trace_valid_o && trace_ready_i;
    assign push          = !clear_i && gnt_any && (!fifo_full || pop);

    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            stage_grant[p] = push && (gnt_idx == PortW'(p));
        end
        n_drop = '0;
        for (int p = 0; p < int'(NrPorts); p++) begin
            n_drop = n_drop + {3'b000, stage_drop[p]};
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{port: gnt_idx,
                                strb: stage_strb[gnt_idx],
                                data: stage_data[gnt_idx]};
        end
        ptr_d = ptr_q;
        if (push) begin
            ptr_d = (gnt_idx == PortW'(NrPorts - 1)) ? '0 : gnt_idx + PortW'(1);
        end
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        usage_d    = usage_q;
        drop_cnt_d = sat_add(drop_cnt_q, n_drop);
        capt_cnt_d = push ? sat_add(capt_cnt_q, 4'd1) : capt_cnt_q;
        ovf_d      = ovf_q || (n_drop != '0);
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            usage_d    = '0;
            drop_cnt_d = '0;
            capt_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AddrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
            if (push && !pop) usage_d = usage_q + (AddrW + 1)'(1);
            if (pop && !push) usage_d = usage_q - (AddrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            ptr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            drop_cnt_q <= '0;
            capt_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            ptr_q      <= ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usage_q    <= usage_d;
            drop_cnt_q <= drop_cnt_d;
            capt_cnt_q <= capt_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Head fields read zero whenever nothing is queued.
    assign head         = mem_q[rd_ptr_q];
    assign trace_data_o = trace_valid_o ? head.data : '0;
    assign trace_strb_o = trace_valid_o ? head.strb : '0;
    assign trace_port_o = trace_valid_o ? head.port : '0;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign capt_cnt_o   = capt_cnt_q;
    assign usage_o      = usage_q;

endmodule

// File: tb/tb_ara_w_tracer.sv
// Bench for ara_w_tracer: vector table, scoreboard on the drain side,
// and directed collision/overflow/clear/reset sequences.
module tb_ara_w_tracer;

    localparam int NP  = 2;
    localparam int DW  = 128;
    localparam int SW  = DW / 8;
    localparam int DEP = 4;
    localparam int PW  = 1;
    localparam int UW  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en_i;
    logic [NP-1:0]         port_en_i;
    logic                  clear_i;
    logic [NP-1:0][DW-1:0] w_data_i;
    logic [NP-1:0][SW-1:0] w_strb_i;
    logic [NP-1:0]         w_valid_i;
    logic [NP-1:0]         w_ready_i;
    logic                  trace_valid_o;
    logic                  trace_ready_i;
    logic [DW-1:0]         trace_data_o;
    logic [SW-1:0]         trace_strb_o;
    logic [PW-1:0]         trace_port_o;
    logic                  overflow_o;
    logic [31:0]           drop_cnt_o;
    logic [31:0]           capt_cnt_o;
    logic [UW-1:0]         usage_o;

    always #5 clk = ~clk;

    ara_w_tracer #(
        .NrPorts     (NP),
        .DataWidth   (DW),
        .Depth       (DEP),
        .FilterEmpty (1'b1),
        .MaskData    (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en_i),
        .port_en_i     (port_en_i),
        .clear_i       (clear_i),
        .w_data_i      (w_data_i),
        .w_strb_i      (w_strb_i),
        .w_valid_i     (w_valid_i),
        .w_ready_i     (w_ready_i),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_data_o  (trace_data_o),
        .trace_strb_o  (trace_strb_o),
        .trace_port_o  (trace_port_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o),
        .capt_cnt_o    (capt_cnt_o),
        .usage_o       (usage_o)
    );

    typedef struct packed {
        logic [PW-1:0] port;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic [PW-1:0] port;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          en;
        logic [NP-1:0] pen;
        logic          rdy;
        bit            cap;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   exp_capt = 0;
    ent_t sb[$];
    ent_t mon_e;
    vec_t vt[8];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask(input logic [DW-1:0] d,
                                           input logic [SW-1:0] s);
        for (int b = 0; b < SW; b++) if (!s[b]) d[b*8 +: 8] = 8'h00;
        return d;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [PW-1:0] p, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic rdy);
        w_valid_i[p] = 1'b1;
        w_ready_i[p] = rdy;
        w_data_i[p]  = d;
        w_strb_i[p]  = s;
    endtask

    task automatic idle();
        w_valid_i = '0;
        w_ready_i = '0;
    endtask

    task automatic expect_beat(input logic [PW-1:0] p, input logic [DW-1:0] d,
                               input logic [SW-1:0] s);
        sb.push_back('{port: p, strb: s, data: mask(d, s)});
        exp_capt++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, DW'(trace_valid_o), '0);
        chk({tag, "_data"},  trace_data_o,       '0);
        chk({tag, "_strb"},  DW'(trace_strb_o),  '0);
        chk({tag, "_port"},  DW'(trace_port_o),  '0);
        chk({tag, "_ovf"},   DW'(overflow_o),    '0);
        chk({tag, "_drop"},  DW'(drop_cnt_o),    '0);
        chk({tag, "_capt"},  DW'(capt_cnt_o),    '0);
        chk({tag, "_usage"}, DW'(usage_o),       '0);
    endtask

    // Drain-side scoreboard: each accepted head must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && trace_valid_o && trace_ready_i) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got port=%0d data=%0h want no entry",
                         trace_port_o, trace_data_o);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_port", DW'(trace_port_o), DW'(mon_e.port));
                chk("sb_data", trace_data_o, mon_e.data);
                chk("sb_strb", DW'(trace_strb_o), DW'(mon_e.strb));
            end
        end
    end

    initial begin
        vt[0] = '{1'b1, {4{32'hA5A5_0001}}, 16'hFFFF, 1'b1, 2'b11, 1'b1, 1'b1};
        vt[1] = '{1'b0, {4{32'h1234_5678}}, 16'h00F0, 1'b1, 2'b11, 1'b1, 1'b1};
        vt[2] = '{1'b0, {4{32'hCAFE_0003}}, 16'h0000, 1'b1, 2'b11, 1'b1, 1'b0};
        vt[3] = '{1'b1, {4{32'hCAFE_0004}}, 16'h8001, 1'b0, 2'b11, 1'b1, 1'b0};
        vt[4] = '{1'b1, {4{32'hCAFE_0005}}, 16'hFFFF, 1'b1, 2'b01, 1'b1, 1'b0};
        vt[5] = '{1'b1, {4{32'h0BAD_F00D}}, 16'h0101, 1'b1, 2'b10, 1'b1, 1'b1};
        vt[6] = '{1'b0, {4{32'hCAFE_0007}}, 16'h1000, 1'b1, 2'b10, 1'b1, 1'b0};
        vt[7] = '{1'b0, {4{32'hCAFE_0008}}, 16'hFFFF, 1'b1, 2'b11, 1'b0, 1'b0};

        en_i          = 1'b1;
        port_en_i     = 2'b11;
        clear_i       = 1'b0;
        w_data_i      = '0;
        w_strb_i      = '0;
        w_valid_i     = '0;
        w_ready_i     = '0;
        trace_ready_i = 1'b0;

        repeat (2) cyc();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        cyc();

        // single beat, drain held: visible two edges after the handshake
        drive(1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_DEAD_BEEF, 16'h000F, 1'b1);
        expect_beat(1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_DEAD_BEEF, 16'h000F);
        cyc();
        idle();
        chk("single_early", DW'(trace_valid_o), '0);
        cyc();
        chk("single_valid", DW'(trace_valid_o), 1);
        chk("single_port", DW'(trace_port_o), 0);
        chk("single_data", trace_data_o, 128'hDEAD_BEEF);
        chk("single_strb", DW'(trace_strb_o), 16'h000F);
        chk("single_capt", DW'(capt_cnt_o), 1);
        trace_ready_i = 1'b1;
        repeat (2) cyc();

        for (int v = 0; v < 8; v++) begin
            en_i      = vt[v].en;
            port_en_i = vt[v].pen;
            drive(vt[v].port, vt[v].data, vt[v].strb, vt[v].rdy);
            if (vt[v].cap) expect_beat(vt[v].port, vt[v].data, vt[v].strb);
            cyc();
            idle();
            en_i      = 1'b1;
            port_en_i = 2'b11;
            repeat (3) cyc();
            chk($sformatf("vec%0d_capt", v), DW'(capt_cnt_o), DW'(exp_capt));
            chk($sformatf("vec%0d_usage", v), DW'(usage_o), '0);
        end
        chk("vec_drop", DW'(drop_cnt_o), '0);

        // collision with pointer at 0: port 0 first, then port 1
        trace_ready_i = 1'b0;
        drive(1'b0, {4{32'hA0A0_A0A0}}, 16'hFFFF, 1'b1);
        drive(1'b1, {4{32'hA1A1_A1A1}}, 16'hFFFF, 1'b1);
        expect_beat(1'b0, {4{32'hA0A0_A0A0}}, 16'hFFFF);
        expect_beat(1'b1, {4{32'hA1A1_A1A1}}, 16'hFFFF);
        cyc();
        idle();
        repeat (2) cyc();
        drive(1'b0, {4{32'hB0B0_B0B0}}, 16'h00FF, 1'b1);
        expect_beat(1'b0, {4{32'hB0B0_B0B0}}, 16'h00FF);
        cyc();
        idle();
        repeat (2) cyc();
        chk("coll1_usage", DW'(usage_o), 3);
        chk("coll1_head", DW'(trace_port_o), 0);
        trace_ready_i = 1'b1;
        repeat (5) cyc();
        trace_ready_i = 1'b0;
        chk("coll1_drained", DW'(usage_o), 0);

        // last grant went to port 0, so port 1 now wins the tie
        drive(1'b0, {4{32'hC0C0_C0C0}}, 16'hF00F, 1'b1);
        drive(1'b1, {4{32'hC1C1_C1C1}}, 16'h0FF0, 1'b1);
        expect_beat(1'b1, {4{32'hC1C1_C1C1}}, 16'h0FF0);
        expect_beat(1'b0, {4{32'hC0C0_C0C0}}, 16'hF00F);
        cyc();
        idle();
        repeat (3) cyc();
        chk("coll2_usage", DW'(usage_o), 2);
        chk("coll2_head", DW'(trace_port_o), 1);
        trace_ready_i = 1'b1;
        repeat (4) cyc();
        trace_ready_i = 1'b0;
        chk("coll2_drained", DW'(usage_o), 0);

        // overflow: 7 back-to-back beats into a 4-deep FIFO with drain stalled
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, {4{32'hD000_0000 + 32'(i)}}, 16'hFFFF, 1'b1);
            if (i <= 5) expect_beat(1'b0, {4{32'hD000_0000 + 32'(i)}}, 16'hFFFF);
            cyc();
        end
        idle();
        chk("ovf_usage", DW'(usage_o), 4);
        chk("ovf_drop", DW'(drop_cnt_o), 2);
        chk("ovf_flag", DW'(overflow_o), 1);
        chk("ovf_capt", DW'(capt_cnt_o), DW'(exp_capt - 1));
        trace_ready_i = 1'b1;
        repeat (8) cyc();
        trace_ready_i = 1'b0;
        chk("ovf_capt_end", DW'(capt_cnt_o), DW'(exp_capt));
        chk("ovf_usage_end", DW'(usage_o), 0);
        chk("ovf_sb_empty", DW'(sb.size()), 0);
        chk("ovf_sticky", DW'(overflow_o), 1);

        // clear at full, with a capture in the same cycle
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, {4{32'hE000_0000 + 32'(i)}}, 16'hFFFF, 1'b1);
            cyc();
        end
        idle();
        chk("clr_pre_usage", DW'(usage_o), 4);
        clear_i = 1'b1;
        drive(1'b1, {4{32'hE1E1_E1E1}}, 16'hFFFF, 1'b1);
        cyc();
        clear_i = 1'b0;
        idle();
        exp_capt = 0;
        chk("clr_usage", DW'(usage_o), 0);
        chk("clr_capt", DW'(capt_cnt_o), 0);
        chk("clr_drop", DW'(drop_cnt_o), 0);
        chk("clr_ovf", DW'(overflow_o), 0);
        chk("clr_valid", DW'(trace_valid_o), 0);
        repeat (3) cyc();
        chk("clr_usage_late", DW'(usage_o), 0);
        chk("clr_valid_late", DW'(trace_valid_o), 0);

        // async reset while draining three queued beats
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, {4{32'hF000_0000 + 32'(i)}}, 16'hFFFF, 1'b1);
            cyc();
        end
        idle();
        cyc();
        chk("rst2_pre_usage", DW'(usage_o), 3);
        trace_ready_i = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk_reset_outputs("rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
